typing_test_core: RTL and testbench

- Parametrised successor of the 4-digit typing-test game controller. Supports N display digits, a single clock domain with a seconds strobe, a sequential target-count loader and a sequential WPM divider.
- Adds a BCD result view that toggles between WPM and missed-key count.
- Sits between the keypad decoder/debouncer, the LFSR word source, and the multiplexed 7-segment driver.

---
 rtl/typing_test_core.sv | 191 +++++++++++++++++++
 tb/tb_typing_test_core.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_test_core.sv
// Typing-test game controller: target entry, timed word matching, sequential
// WPM divide and BCD conversion of the result for a multiplexed digit display.
module typing_test_core #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 20,
  parameter int TIME_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sec_tick,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic [4*DIGITS-1:0] rand_word,
  output logic [DIGITS-1:0]   digit_en,
  output logic [4*DIGITS-1:0] digit_val,
  output logic [1:0]          mode,
  output logic                done
);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int DW    = CNT_W + 6;
  localparam int BW    = 4 * DIGITS;
  localparam int PTR_W = $clog2(DIGITS);
  localparam int CW    = $clog2(DW + 1);
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(pow10(DIGITS) - 1);
  localparam logic [DW-1:0]    SAT_Q   = DW'(pow10(DIGITS) - 1);

  typedef enum logic [2:0] {S_SELECT, S_LOAD, S_TEST, S_CALC, S_CONV, S_RESULT} state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      buf_q, buf_d, word_q, word_d;
  logic [CNT_W-1:0]   target_q, target_d, completed_q, completed_d, missed_q, missed_d;
  logic [DIGITS-1:0]  mask_q, mask_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [TIME_W-1:0]  elapsed_q, elapsed_d, rem_q, rem_d, div_q, div_d;
  logic               view_q, view_d, done_q, done_d, key_prev_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      dvd_q, dvd_d;
  logic [CNT_W-1:0]   bin_w_q, bin_w_d, bin_m_q, bin_m_d;
  logic [BW-1:0]      bcd_w_q, bcd_w_d, bcd_m_q, bcd_m_d;
  logic [DIGITS-1:0]  disp_en_q, disp_en_d;
  logic [BW-1:0]      disp_val_q, disp_val_d;

  logic               key_ev;
  logic [3:0]         cur_dig, ld_dig;
  logic [PTR_W-1:0]   ld_idx;
  logic [TIME_W:0]    rem_sh;
  logic               q_bit;
  logic [TIME_W-1:0]  rem_sub;
  logic [DW-1:0]      quot;
  logic [BW-1:0]      adj_w, adj_m;

  assign key_ev  = key_valid & ~key_prev_q;
  assign cur_dig = word_q[{ptr_q, 2'b00} +: 4];
  assign ld_idx  = PTR_TOP - cnt_q[PTR_W-1:0];
  assign ld_dig  = buf_q[{ld_idx, 2'b00} +: 4];

  // Restoring divide step: the quotient bit shifts into the vacated dividend LSB.
  assign rem_sh  = {rem_q, dvd_q[DW-1]};
  assign q_bit   = (rem_sh >= {1'b0, div_q});
  assign rem_sub = q_bit ? TIME_W'(rem_sh - {1'b0, div_q}) : rem_sh[TIME_W-1:0];
  assign quot    = {dvd_q[DW-2:0], q_bit};

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj_w[4*gi +: 4] = (bcd_w_q[4*gi +: 4] >= 4'd5) ? bcd_w_q[4*gi +: 4] + 4'd3 : bcd_w_q[4*gi +: 4];
      assign adj_m[4*gi +: 4] = (bcd_m_q[4*gi +: 4] >= 4'd5) ? bcd_m_q[4*gi +: 4] + 4'd3 : bcd_m_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_d = state_q;   buf_d = buf_q;           target_d = target_q;
    word_d = word_q;     mask_d = mask_q;         ptr_d = ptr_q;
    completed_d = completed_q; missed_d = missed_q; elapsed_d = elapsed_q;
    view_d = view_q;     cnt_d = cnt_q;           dvd_d = dvd_q;
    rem_d = rem_q;       div_d = div_q;           done_d = 1'b0;
    bin_w_d = bin_w_q;   bin_m_d = bin_m_q;       bcd_w_d = bcd_w_q;  bcd_m_d = bcd_m_q;
    if (key_ev && key_code == 4'hB) begin
      state_d = S_SELECT;
      completed_d = '0; missed_d = '0; elapsed_d = '0;
      mask_d = '1; cnt_d = '0;
    end else begin
      unique case (state_q)
        S_SELECT: if (key_ev) begin
          if (key_code <= 4'd9) begin
            buf_d = {buf_q[BW-5:0], key_code};
          end else if (key_code == 4'hA && buf_q != '0) begin
            state_d = S_LOAD; target_d = '0; cnt_d = '0;
            completed_d = '0; missed_d = '0; elapsed_d = '0;
          end
        end
        S_LOAD: begin
          target_d = target_q * CNT_W'(10) + CNT_W'(ld_dig);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DIGITS - 1)) begin
            state_d = S_TEST; word_d = rand_word; ptr_d = PTR_TOP; mask_d = '1;
          end
        end
        S_TEST: begin
          if (sec_tick && elapsed_q != '1) elapsed_d = elapsed_q + TIME_W'(1);
          if (key_ev) begin
            if (key_code == cur_dig) begin
              mask_d[ptr_q] = 1'b0;
              ptr_d = ptr_q - PTR_W'(1);
              if (ptr_q == '0) begin
                completed_d = completed_q + CNT_W'(1);
                word_d = rand_word; mask_d = '1; ptr_d = PTR_TOP;
                if (completed_d == target_q) begin
                  state_d = S_CALC; cnt_d = '0; rem_d = '0;
                  dvd_d = DW'(completed_d) * DW'(60);
                  div_d = (elapsed_d == '0) ? TIME_W'(1) : elapsed_d;
                end
              end
            end else if (missed_q != '1) begin
              missed_d = missed_q + CNT_W'(1);
            end
          end
        end
        S_CALC: begin
          dvd_d = quot; rem_d = rem_sub; cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            state_d = S_CONV; cnt_d = '0; bcd_w_d = '0; bcd_m_d = '0;
            bin_w_d = (quot > SAT_Q) ? SAT_C : quot[CNT_W-1:0];
            bin_m_d = (missed_q > SAT_C) ? SAT_C : missed_q;
          end
        end
        S_CONV: begin
          {bcd_w_d, bin_w_d} = {adj_w, bin_w_q} << 1;
          {bcd_m_d, bin_m_d} = {adj_m, bin_m_q} << 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(CNT_W - 1)) begin
            state_d = S_RESULT; done_d = 1'b1; view_d = 1'b0;
          end
        end
        S_RESULT: if (key_ev && key_code == 4'hA) view_d = ~view_q;
        default: state_d = S_SELECT;
      endcase
    end
  end

  // Display registers follow the registered state, so they trail it by a cycle.
  always_comb begin
    disp_en_d  = '1;
    disp_val_d = '0;
    unique case (state_q)
      S_SELECT: disp_val_d = buf_q;
      S_TEST:   begin disp_en_d = mask_q; disp_val_d = word_q; end
      S_RESULT: disp_val_d = view_q ? bcd_m_q : bcd_w_q;
      default:  disp_en_d = '0;
    endcase
  end

  always_comb begin
    unique case (state_q)
      S_SELECT: mode = 2'd0;
      S_TEST:   mode = 2'd1;
      S_RESULT: mode = 2'd2;
      default:  mode = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_SELECT; buf_q <= '0; target_q <= '0; word_q <= '0;
      mask_q <= '1; ptr_q <= '0; completed_q <= '0; missed_q <= '0;
      elapsed_q <= '0; view_q <= 1'b0; cnt_q <= '0; dvd_q <= '0;
      rem_q <= '0; div_q <= '0; done_q <= 1'b0; key_prev_q <= 1'b0;
      bin_w_q <= '0; bin_m_q <= '0; bcd_w_q <= '0; bcd_m_q <= '0;
      disp_en_q <= '1; disp_val_q <= '0;
    end else begin
      state_q <= state_d; buf_q <= buf_d; target_q <= target_d; word_q <= word_d;
      mask_q <= mask_d; ptr_q <= ptr_d; completed_q <= completed_d; missed_q <= missed_d;
      elapsed_q <= elapsed_d; view_q <= view_d; cnt_q <= cnt_d; dvd_q <= dvd_d;
      rem_q <= rem_d; div_q <= div_d; done_q <= done_d; key_prev_q <= key_valid;
      bin_w_q <= bin_w_d; bin_m_q <= bin_m_d; bcd_w_q <= bcd_w_d; bcd_m_q <= bcd_m_d;
      disp_en_q <= disp_en_d; disp_val_q <= disp_val_d;
    end
  end

  assign digit_en  = disp_en_q;
  assign digit_val = disp_val_q;
  assign done      = done_q;

endmodule

// File: tb/tb_typing_test_core.sv
// Randomized bench for typing_test_core: a keystroke-level game model predicts
// target, word latching, miss/elapsed counts and the displayed WPM/missed BCD.
module tb_typing_test_core;
  localparam int D = 4;
  localparam int CNTW = 20;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sec_tick = 1'b0;
  logic           key_valid = 1'b0;
  logic [3:0]     key_code = 4'h0;
  logic [4*D-1:0] rand_word = '0;
  logic [D-1:0]   digit_en;
  logic [4*D-1:0] digit_val;
  logic [1:0]     mode;
  logic           done;

  typing_test_core #(.DIGITS(D), .CNT_W(CNTW), .TIME_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .key_valid(key_valid),
    .key_code(key_code), .rand_word(rand_word), .digit_en(digit_en),
    .digit_val(digit_val), .mode(mode), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int m_missed, m_el, m_comp;
  logic [4*D-1:0] cur_word;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int x;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4*D-1:0] rand_w();
    logic [4*D-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; key_valid = 1'b0; sec_tick = 1'b0; key_code = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One key event; returns when the registered display reflects it.
  task automatic press(input logic [3:0] c, input bit tick);
    key_code = c; key_valid = 1'b1; sec_tick = tick;
    @(negedge clk);
    key_valid = 1'b0; sec_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  task automatic enter_target(input int t);
    int pw;
    pw = 1;
    for (int i = 1; i < D; i++) pw = pw * 10;
    for (int i = 0; i < D; i++) begin
      press(4'((t / pw) % 10), 1'b0);
      pw = pw / 10;
    end
    total++;
    if (digit_val !== to_bcd(t)) begin
      bad++; $display("FAIL select_buf: got %h want %h", digit_val, to_bcd(t));
    end
  endtask

  task automatic start_load();
    int n;
    key_code = 4'hA; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    n = 0;
    while (mode === 2'd3 && n < 50) begin n++; @(negedge clk); end
    total++;
    if (n != D) begin bad++; $display("FAIL load_busy: got %0d cycles want %0d", n, D); end
    total++;
    if (mode !== 2'd1) begin bad++; $display("FAIL load_mode: got %0d want 1", mode); end
    @(negedge clk);
    cur_word = rand_word;
    m_missed = 0; m_el = 0; m_comp = 0;
    total++;
    if (digit_val !== cur_word) begin bad++; $display("FAIL load_word: got %h want %h", digit_val, cur_word); end
    total++;
    if (digit_en !== 4'hF) begin bad++; $display("FAIL load_en: got %b want 1111", digit_en); end
  endtask

  task automatic play(input int tgt, input int tick_pct, input int miss_pct, input bit final_tick);
    logic [3:0] dig, k;
    logic [4*D-1:0] lw;
    logic [D-1:0] exp_en;
    bit t, last;
    int n, d0, wpm, mis;
    d0 = done_cnt;
    for (int w = 0; w < tgt; w++) begin
      for (int p = D - 1; p >= 0; p--) begin
        dig = cur_word[4*p +: 4];
        if ($urandom_range(0, 99) < miss_pct) begin
          do k = 4'($urandom_range(0, 15)); while (k == dig || k == 4'hB);
          t = ($urandom_range(0, 99) < tick_pct);
          if (t) m_el++;
          m_missed++;
          press(k, t);
          exp_en = D'((1 << (p + 1)) - 1);
          total++;
          if (digit_en !== exp_en) begin bad++; $display("FAIL miss_en: got %b want %b", digit_en, exp_en); end
        end
        last = (w == tgt - 1) && (p == 0);
        t = last ? final_tick : ($urandom_range(0, 99) < tick_pct);
        if (t) m_el++;
        if (last) begin
          d0 = done_cnt;
          key_code = dig; key_valid = 1'b1; sec_tick = t;
          @(negedge clk);
          key_valid = 1'b0; sec_tick = 1'b0;
          m_comp++;
        end else if (p > 0) begin
          press(dig, t);
          exp_en = D'((1 << p) - 1);
          total++;
          if (digit_en !== exp_en) begin bad++; $display("FAIL key_en: got %b want %b", digit_en, exp_en); end
        end else begin
          lw = rand_word;
          press(dig, t);
          m_comp++;
          total++;
          if (digit_en !== 4'hF || digit_val !== lw) begin
            bad++; $display("FAIL word_latch: got en=%b val=%h want en=1111 val=%h", digit_en, digit_val, lw);
          end
          cur_word = lw;
          rand_word = rand_w();
        end
      end
    end
    n = 0;
    while (mode === 2'd3 && n < 200) begin n++; @(negedge clk); end
    total++;
    if (n < CNTW + 6) begin bad++; $display("FAIL calc_busy: got %0d cycles want >= %0d", n, CNTW + 6); end
    total++;
    if (mode !== 2'd2) begin bad++; $display("FAIL result_mode: got %0d want 2", mode); end
    @(negedge clk);
    wpm = (m_comp * 60) / ((m_el == 0) ? 1 : m_el);
    if (wpm > 9999) wpm = 9999;
    mis = (m_missed > 9999) ? 9999 : m_missed;
    total++;
    if (digit_val !== to_bcd(wpm) || digit_en !== 4'hF) begin
      bad++; $display("FAIL wpm: got val=%h en=%b want val=%h en=1111", digit_val, digit_en, to_bcd(wpm));
    end
    press(4'hA, 1'b0);
    total++;
    if (digit_val !== to_bcd(mis)) begin bad++; $display("FAIL view_missed: got %h want %h", digit_val, to_bcd(mis)); end
    press(4'h5, 1'b0);
    total++;
    if (digit_val !== to_bcd(mis)) begin bad++; $display("FAIL result_digit_ignored: got %h want %h", digit_val, to_bcd(mis)); end
    press(4'hA, 1'b0);
    total++;
    if (digit_val !== to_bcd(wpm)) begin bad++; $display("FAIL view_wpm: got %h want %h", digit_val, to_bcd(wpm)); end
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL done_pulse: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (mode !== 2'd0 || digit_en !== 4'hF || digit_val !== 16'h0 || done !== 1'b0) begin
      bad++; $display("FAIL reset: got mode=%0d en=%b val=%h done=%b want 0 1111 0000 0", mode, digit_en, digit_val, done);
    end
  endtask

  task automatic test_select();
    do_reset();
    press(4'hA, 1'b0);
    total++;
    if (mode !== 2'd0 || digit_en !== 4'hF) begin bad++; $display("FAIL zero_start: got mode=%0d en=%b want 0 1111", mode, digit_en); end
    press(4'hC, 1'b0);
    total++;
    if (digit_val !== 16'h0) begin bad++; $display("FAIL key_c_ignored: got %h want 0000", digit_val); end
    press(4'h0, 1'b0); press(4'h0, 1'b0); press(4'h1, 1'b0); press(4'h2, 1'b0);
    total++;
    if (digit_val !== 16'h0012) begin bad++; $display("FAIL shift: got %h want 0012", digit_val); end
    press(4'h7, 1'b0); press(4'h8, 1'b0); press(4'h9, 1'b0);
    total++;
    if (digit_val !== 16'h2789) begin bad++; $display("FAIL shift_drop: got %h want 2789", digit_val); end
  endtask

  task automatic test_game(input int tgt, input logic [15:0] w0, input int pre, input int tp, input int mp, input bit ft);
    do_reset();
    rand_word = w0;
    enter_target(tgt);
    start_load();
    for (int i = 0; i < pre; i++) tick();
    m_el = m_el + pre;
    play(tgt, tp, mp, ft);
  endtask

  task automatic test_abort();
    logic [3:0] dig;
    do_reset();
    rand_word = rand_w();
    enter_target(3);
    start_load();
    repeat (3) tick();
    dig = cur_word[4*(D-1) +: 4];
    press(4'((dig + 1) % 10), 1'b0);
    press(dig, 1'b0);
    key_code = 4'hB; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    total++;
    if (mode !== 2'd0) begin bad++; $display("FAIL abort_mode: got %0d want 0", mode); end
    @(negedge clk);
    total++;
    if (digit_en !== 4'hF || digit_val !== 16'h0003) begin
      bad++; $display("FAIL abort_disp: got en=%b val=%h want 1111 0003", digit_en, digit_val);
    end
    rand_word = rand_w();
    start_load();
    play(3, 0, 20, 1'b0);
  endtask

  task automatic test_reset_calc();
    int d0;
    do_reset();
    rand_word = rand_w();
    enter_target(1);
    start_load();
    for (int p = D - 1; p > 0; p--) press(cur_word[4*p +: 4], 1'b0);
    d0 = done_cnt;
    key_code = cur_word[3:0]; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (mode !== 2'd3) begin bad++; $display("FAIL calc_mid_mode: got %0d want 3", mode); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (mode !== 2'd0) begin bad++; $display("FAIL rst_mid_mode: got %0d want 0", mode); end
    repeat (100) @(negedge clk);
    total++;
    if (done_cnt != d0) begin bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", done_cnt - d0); end
    total++;
    if (digit_en !== 4'hF || digit_val !== 16'h0) begin
      bad++; $display("FAIL rst_mid_disp: got en=%b val=%h want 1111 0000", digit_en, digit_val);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      test_game($urandom_range(1, 6), rand_w(), $urandom_range(0, 5),
                $urandom_range(0, 50), $urandom_range(0, 40), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_game(12, rand_w(), 0, 20, 20, 1'b0);
    test_game(2, 16'h3571, 30, 0, 30, 1'b0);
    test_game(1, rand_w(), 0, 0, 0, 1'b0);
    test_game(200, rand_w(), 0, 0, 0, 1'b0);
    test_game(2, rand_w(), 4, 0, 10, 1'b1);
    test_abort();
    test_reset_calc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
